// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter/sequencer sharing one fixed-latency memory port between IF and DM.
// Access takes LATENCY+1 cycles to ack; losing requester is stalled until its own ack.
module data_mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_stall_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                last_dm_q, last_dm_d;
  logic                sel_dm_q, sel_dm_d;
  logic                sel_we_q, sel_we_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                any_req;
  logic                grant_dm;

  assign any_req  = if_req_i | dm_req_i;
  // On a tie the side that did not win last time gets the port.
  assign grant_dm = dm_req_i & (~if_req_i | ~last_dm_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_dm_q   <= 1'b1;
      sel_dm_q    <= 1'b0;
      sel_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_data_q   <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dm_q   <= last_dm_d;
      sel_dm_q    <= sel_dm_d;
      sel_we_q    <= sel_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_data_q   <= if_data_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    last_dm_d   = last_dm_q;
    sel_dm_d    = sel_dm_q;
    sel_we_d    = sel_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_data_d   = if_data_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          cnt_d      = 4'(LATENCY - 1);
          mem_en_d   = 1'b1;
          mem_we_d   = grant_dm & dm_we_i;
          mem_addr_d = grant_dm ? dm_addr_i : if_addr_i;
          if (grant_dm) mem_wdata_d = dm_wdata_i;
          last_dm_d  = grant_dm;
          sel_dm_d   = grant_dm;
          sel_we_d   = grant_dm & dm_we_i;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (sel_dm_q) begin
          dm_ack_d = 1'b1;
          if (!sel_we_q) dm_rdata_d = mem_rdata_i;
        end else begin
          if_ack_d  = 1'b1;
          if_data_d = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_data_o   = if_data_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign dm_stall_o  = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: instance a uses LATENCY=2 with a one-cycle-late
// memory, instance b uses LATENCY=1 with a combinational memory.
module tb_data_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b1;
  int   vecs = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  logic        a_if_req = 0, a_dm_req = 0, a_dm_we = 0;
  logic [31:0] a_if_addr = 0, a_dm_addr = 0, a_dm_wdata = 0;
  logic        a_if_ack, a_if_stall, a_dm_ack, a_dm_stall, a_mem_en, a_mem_we;
  logic [31:0] a_if_data, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_if_req = 0, b_dm_req = 0, b_dm_we = 0;
  logic [31:0] b_if_addr = 0, b_dm_addr = 0, b_dm_wdata = 0;
  logic        b_if_ack, b_if_stall, b_dm_ack, b_dm_stall, b_mem_en, b_mem_we;
  logic [31:0] b_if_data, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  data_mem_arbiter #(.LATENCY(2), .ADDR_W(32), .DATA_W(32)) u_a (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(a_if_req), .if_addr_i(a_if_addr), .if_ack_o(a_if_ack),
    .if_data_o(a_if_data), .if_stall_o(a_if_stall),
    .dm_req_i(a_dm_req), .dm_we_i(a_dm_we), .dm_addr_i(a_dm_addr),
    .dm_wdata_i(a_dm_wdata), .dm_ack_o(a_dm_ack), .dm_rdata_o(a_dm_rdata),
    .dm_stall_o(a_dm_stall), .mem_en_o(a_mem_en), .mem_we_o(a_mem_we),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata)
  );

  data_mem_arbiter #(.LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_b (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack),
    .if_data_o(b_if_data), .if_stall_o(b_if_stall),
    .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr),
    .dm_wdata_i(b_dm_wdata), .dm_ack_o(b_dm_ack), .dm_rdata_o(b_dm_rdata),
    .dm_stall_o(b_dm_stall), .mem_en_o(b_mem_en), .mem_we_o(b_mem_we),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata)
  );

  // Memory models: data only valid in the cycle the arbiter is supposed to sample it.
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic        a_en_d1 = 1'b0;

  always @(posedge clk) begin
    a_en_d1 <= a_mem_en;
    if (load) begin
      mem_a[16] <= 32'hDEADBEEF;
      mem_b[16] <= 32'hCAFEF00D;
      mem_b[32] <= 32'hA5A55A5A;
    end else begin
      if (a_mem_en && a_mem_we) mem_a[a_mem_addr[5:0]] <= a_mem_wdata;
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr[5:0]] <= b_mem_wdata;
    end
  end

  assign a_mem_rdata = a_en_d1  ? mem_a[a_mem_addr[5:0]] : 32'hBAD0BAD0;
  assign b_mem_rdata = b_mem_en ? mem_b[b_mem_addr[5:0]] : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    load = 1'b0;
    tick();
    vecs++; if (a_mem_en !== 1'b0) begin miss++; $display("FAIL rst_a_en got %h exp 0", a_mem_en); end
    vecs++; if ({a_if_ack, a_dm_ack} !== 2'b00) begin miss++; $display("FAIL rst_a_ack got %b exp 00", {a_if_ack, a_dm_ack}); end
    vecs++; if (a_mem_addr !== 32'h0) begin miss++; $display("FAIL rst_a_addr got %h exp 0", a_mem_addr); end
    vecs++; if ({b_mem_en, b_mem_we, b_if_ack, b_dm_ack} !== 4'b0000) begin miss++; $display("FAIL rst_b_ctl got %b exp 0000", {b_mem_en, b_mem_we, b_if_ack, b_dm_ack}); end
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    tick();
    a_if_req = 1'b1; a_if_addr = 32'h10;
    #1;
    vecs++; if (a_if_stall !== 1'b1) begin miss++; $display("FAIL ifrd_stall_c0 got %h exp 1", a_if_stall); end
    tick();
    vecs++; if ({a_mem_en, a_mem_we} !== 2'b10) begin miss++; $display("FAIL ifrd_en_we_c1 got %b exp 10", {a_mem_en, a_mem_we}); end
    vecs++; if (a_mem_addr !== 32'h10) begin miss++; $display("FAIL ifrd_addr_c1 got %h exp 10", a_mem_addr); end
    vecs++; if (a_if_stall !== 1'b1) begin miss++; $display("FAIL ifrd_stall_c1 got %h exp 1", a_if_stall); end
    tick();
    vecs++; if ({a_mem_en, a_if_ack, a_if_stall} !== 3'b001) begin miss++; $display("FAIL ifrd_c2 got %b exp 001", {a_mem_en, a_if_ack, a_if_stall}); end
    tick();
    vecs++; if (a_if_ack !== 1'b1) begin miss++; $display("FAIL ifrd_ack_c3 got %h exp 1", a_if_ack); end
    vecs++; if (a_if_data !== 32'hDEADBEEF) begin miss++; $display("FAIL ifrd_data_c3 got %h exp deadbeef", a_if_data); end
    vecs++; if (a_if_stall !== 1'b0) begin miss++; $display("FAIL ifrd_stall_c3 got %h exp 0", a_if_stall); end
    tick();
    a_if_req = 1'b0;
    vecs++; if (a_if_ack !== 1'b0) begin miss++; $display("FAIL ifrd_ack_c4 got %h exp 0", a_if_ack); end
  endtask

  task automatic test_dm_write_read();
    tick();
    a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h20; a_dm_wdata = 32'h12345678;
    tick();
    vecs++; if ({a_mem_en, a_mem_we} !== 2'b11) begin miss++; $display("FAIL dmwr_en_we_c1 got %b exp 11", {a_mem_en, a_mem_we}); end
    vecs++; if (a_mem_wdata !== 32'h12345678) begin miss++; $display("FAIL dmwr_wdata got %h exp 12345678", a_mem_wdata); end
    tick();
    vecs++; if ({a_mem_en, a_mem_we} !== 2'b00) begin miss++; $display("FAIL dmwr_en_we_c2 got %b exp 00", {a_mem_en, a_mem_we}); end
    tick();
    vecs++; if (a_dm_ack !== 1'b1) begin miss++; $display("FAIL dmwr_ack_c3 got %h exp 1", a_dm_ack); end
    vecs++; if (a_dm_rdata !== 32'h0) begin miss++; $display("FAIL dmwr_rdata got %h exp 0", a_dm_rdata); end
    tick();
    a_dm_we = 1'b0;
    tick();
    vecs++; if ({a_mem_en, a_mem_we} !== 2'b10) begin miss++; $display("FAIL dmrd_en_we_c5 got %b exp 10", {a_mem_en, a_mem_we}); end
    tick();
    tick();
    vecs++; if (a_dm_ack !== 1'b1) begin miss++; $display("FAIL dmrd_ack_c7 got %h exp 1", a_dm_ack); end
    vecs++; if (a_dm_rdata !== 32'h12345678) begin miss++; $display("FAIL dmrd_rdata got %h exp 12345678", a_dm_rdata); end
    tick();
    a_dm_req = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    tick();
    a_if_req = 1'b1; a_if_addr = 32'h10;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h20;
    tick();
    vecs++; if (a_mem_addr !== 32'h10) begin miss++; $display("FAIL sim_first_addr got %h exp 10", a_mem_addr); end
    tick();
    tick();
    vecs++; if ({a_if_ack, a_dm_ack, a_dm_stall} !== 3'b101) begin miss++; $display("FAIL sim_c3 got %b exp 101", {a_if_ack, a_dm_ack, a_dm_stall}); end
    tick();
    a_if_req = 1'b0;
    tick();
    vecs++; if ({a_mem_en, a_mem_addr} !== {1'b1, 32'h20}) begin miss++; $display("FAIL sim_dm_en_c5 got %b/%h exp 1/20", a_mem_en, a_mem_addr); end
    tick();
    tick();
    vecs++; if ({a_dm_ack, a_dm_rdata} !== {1'b1, 32'h12345678}) begin miss++; $display("FAIL sim_dm_ack_c7 got %b/%h exp 1/12345678", a_dm_ack, a_dm_rdata); end
    tick();
    a_dm_req = 1'b0;
  endtask

  task automatic test_contention();
    logic [5:0] seq;
    int nack;
    int both;
    seq = '0; nack = 0; both = 0;
    do_reset();
    tick();
    a_if_req = 1'b1; a_if_addr = 32'h10;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h20;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (a_if_ack && a_dm_ack) both++;
      if (a_if_ack || a_dm_ack) begin
        nack++;
        seq = {seq[4:0], a_dm_ack};
      end
    end
    a_if_req = 1'b0; a_dm_req = 1'b0;
    vecs++; if (nack !== 6) begin miss++; $display("FAIL cont_nack got %0d exp 6", nack); end
    vecs++; if (seq !== 6'b010101) begin miss++; $display("FAIL cont_order got %b exp 010101", seq); end
    vecs++; if (both !== 0) begin miss++; $display("FAIL cont_dual_ack got %0d exp 0", both); end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    int if_acks;
    lat = 0; if_acks = 0;
    tick();
    a_if_req = 1'b1; a_if_addr = 32'h10;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vecs++; if ({a_if_ack, a_dm_ack, a_mem_en, a_mem_we} !== 4'b0000) begin miss++; $display("FAIL rmb_ctl got %b exp 0000", {a_if_ack, a_dm_ack, a_mem_en, a_mem_we}); end
    vecs++; if ({a_mem_addr, a_mem_wdata} !== 64'h0) begin miss++; $display("FAIL rmb_addr_wdata got %h/%h exp 0/0", a_mem_addr, a_mem_wdata); end
    vecs++; if ({a_if_data, a_dm_rdata} !== 64'h0) begin miss++; $display("FAIL rmb_rdata got %h/%h exp 0/0", a_if_data, a_dm_rdata); end
    rst = 1'b0; a_if_req = 1'b0;
    tick();
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h20;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (a_if_ack) if_acks++;
      if (a_dm_ack) begin
        lat = k;
        break;
      end
    end
    vecs++; if (lat !== 3) begin miss++; $display("FAIL rmb_dm_latency got %0d exp 3", lat); end
    vecs++; if (a_dm_rdata !== 32'h12345678) begin miss++; $display("FAIL rmb_dm_rdata got %h exp 12345678", a_dm_rdata); end
    vecs++; if (if_acks !== 0) begin miss++; $display("FAIL rmb_stray_if_ack got %0d exp 0", if_acks); end
    tick();
    a_dm_req = 1'b0;
  endtask

  task automatic test_latency1();
    tick();
    b_if_req = 1'b1; b_if_addr = 32'h10;
    tick();
    vecs++; if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h10}) begin miss++; $display("FAIL l1_en_c1 got %b/%h exp 1/10", b_mem_en, b_mem_addr); end
    tick();
    vecs++; if ({b_if_ack, b_if_stall} !== 2'b10) begin miss++; $display("FAIL l1_ack_c2 got %b exp 10", {b_if_ack, b_if_stall}); end
    vecs++; if (b_if_data !== 32'hCAFEF00D) begin miss++; $display("FAIL l1_data got %h exp cafef00d", b_if_data); end
    tick();
    b_if_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int en_cyc [3];
    int n;
    logic [31:0] dm_seen;
    n = 0; dm_seen = '0;
    en_cyc[0] = 0; en_cyc[1] = 0; en_cyc[2] = 0;
    do_reset();
    tick();
    b_if_req = 1'b1; b_if_addr = 32'h10;
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 32'h20;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (b_mem_en && n < 3) begin
        en_cyc[n] = k;
        n++;
      end
      if (b_dm_ack) dm_seen = b_dm_rdata;
    end
    b_if_req = 1'b0; b_dm_req = 1'b0;
    vecs++; if (en_cyc[0] !== 1) begin miss++; $display("FAIL b2b_first_en got %0d exp 1", en_cyc[0]); end
    vecs++; if (en_cyc[1] !== 4) begin miss++; $display("FAIL b2b_second_en got %0d exp 4", en_cyc[1]); end
    vecs++; if (en_cyc[2] !== 7) begin miss++; $display("FAIL b2b_third_en got %0d exp 7", en_cyc[2]); end
    vecs++; if (dm_seen !== 32'hA5A55A5A) begin miss++; $display("FAIL b2b_dm_rdata got %h exp a5a55a5a", dm_seen); end
    tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_write_read();
    test_simultaneous();
    test_contention();
    test_reset_mid_busy();
    test_latency1();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter and sequencer for a single-port, fixed-latency data memory. Instruction fetch (IF) and data access (DM) share one memory port. The block grants one access at a time with round-robin priority, drives the memory strobes, captures read data and returns a one-cycle acknowledge. It also produces per-requester stall signals that the pipeline uses to freeze PC/IF_ID (IF side) or the whole pipe (DM side) while an access is outstanding.

## Interface
- `LATENCY`, default 2: memory access latency in cycles. Legal range 1..15.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

- `clk_i`, in, 1: clock. Single clock domain; all state updates on the rising edge.
- `rst_i`, in, 1: reset. Synchronous, active-high.
- `if_req_i`, in, 1: IF read request. Held high with a stable address until `if_ack_o`.
- `if_addr_i`, in, ADDR_W: IF address.
- `if_ack_o`, out, 1: one-cycle completion pulse for IF.
- `if_data_o`, out, DATA_W: IF read data, registered, valid when `if_ack_o` is high and held until the next IF completion.
- `if_stall_o`, out, 1: `if_req_i & ~if_ack_o`, combinational.
- `dm_req_i`, in, 1: DM request. Held high with stable payload until `dm_ack_o`.
- `dm_we_i`, in, 1: 1 = write, 0 = read.
- `dm_addr_i`, in, ADDR_W: DM address.
- `dm_wdata_i`, in, DATA_W: DM write data.
- `dm_ack_o`, out, 1: one-cycle completion pulse for DM.
- `dm_rdata_o`, out, DATA_W: DM read data, registered. Unchanged by writes.
- `dm_stall_o`, out, 1: `dm_req_i & ~dm_ack_o`, combinational.
- `mem_en_o`, out, 1: access strobe. High for exactly one cycle per access.
- `mem_we_o`, out, 1: write enable. Only ever high while `mem_en_o` is high.
- `mem_addr_o`, out, ADDR_W: registered address, held for the whole BUSY phase.
- `mem_wdata_o`, out, DATA_W: registered write data, held for the whole BUSY phase.
- `mem_rdata_i`, in, DATA_W: memory read data. Valid in the last BUSY cycle, i.e. LATENCY-1 cycles after `mem_en_o`.

## Operation
- **State machine:** IDLE, BUSY, ACK. A 4-bit down-counter `cnt` and a `last_grant` flag (IF/DM) support it.
- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester that is not `last_grant`.
  - On grant:
    - go to BUSY and set `cnt <= LATENCY-1`;
    - register `mem_addr_o` and `mem_wdata_o`;
    - set `mem_en_o <= 1` and `mem_we_o <= dm_we_i` (DM grant) or `0` (IF grant);
    - update `last_grant`.
- **BUSY**
  - `mem_en_o` and `mem_we_o` return to 0 after the first BUSY cycle.
  - `cnt` decrements each cycle.
  - At `cnt == 0`:
    - capture `mem_rdata_i` into `if_data_o`, or into `dm_rdata_o` for a DM read (not for a DM write);
    - pulse the granted requester's ack by registering it to 1;
    - go to ACK.
- **ACK**
  - The ack is high in this cycle.
  - Requests are ignored, so a still-high `req` is not re-granted.
  - Go to IDLE.
- **Requester rule:** the requester drops `req` or presents a new request in the cycle after the ack. Withdrawing a request before its ack is a protocol violation and the behaviour is undefined.
- **Reset** (also mid-access):
  - all state goes to IDLE;
  - every output register goes to 0: acks, `mem_en_o`, `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `if_data_o`, `dm_rdata_o`;
  - `cnt` goes to 0 and `last_grant` to DM, so IF wins the first tie;
  - an aborted access never produces an ack.

## Timing
- Cycle 0 is the IDLE cycle in which `req` is sampled high.
  - `mem_en_o` is high in cycle 1.
  - BUSY spans cycles 1..LATENCY.
  - The ack is high in cycle LATENCY+1.
  - IDLE returns in cycle LATENCY+2.
- Access latency is LATENCY+1 cycles. Minimum spacing between grants is LATENCY+2 cycles.
- LATENCY=1 with a combinational memory: `mem_rdata_i` is sampled in the same cycle as `mem_en_o`.
- Stall signals fall in the ack cycle, so the pipeline advances on the edge that ends the ack cycle.
- The losing requester's stall stays high throughout the winner's access.

## Test plan
- **IF read, LATENCY=2:** memory[0x10]=0xDEADBEEF; `if_req_i` in cycle 0 with address 0x10 -> `mem_en_o`=1, `mem_addr_o`=0x10, `mem_we_o`=0 in cycle 1; `if_ack_o`=1 with `if_data_o`=0xDEADBEEF in cycle 3; `if_stall_o` high in cycles 0-2.
- **DM write then read:** write 0x12345678 to 0x20 -> `mem_en_o`=`mem_we_o`=1 in cycle 1, `dm_ack_o` in cycle 3, `dm_rdata_o` unchanged; then a read of 0x20 -> `dm_rdata_o`=0x12345678 at its ack.
- **Simultaneous after reset:** IF and DM both request in cycle 0 -> IF granted (`if_ack_o` cycle 3); DM `mem_en_o` in cycle 5, `dm_ack_o` in cycle 7.
- **Sustained contention:** both requests held high (re-issued after each ack) for 24 cycles -> 6 acks, strictly alternating IF, DM, IF, DM, IF, DM.
- **Reset mid-BUSY:** `rst_i` high in cycle 2 of an IF read -> no `if_ack_o`; all outputs 0 in cycle 3; a fresh DM read afterwards completes in LATENCY+1 cycles.
- **LATENCY=1 with combinational memory:** IF read -> `mem_en_o` in cycle 1, `if_ack_o` in cycle 2 with correct data; back-to-back grants 3 cycles apart.
